// File: rtl/axi_probe.sv
// Debug AXI3 initiator: issues one programmed single-beat read or write and records
// response, read data and latency; pulses trig when the response outlasts TIMEOUT.
module axi_probe #(
    parameter logic [31:0] BASEADDR  = 32'h0000_0000,
    parameter int unsigned CNTRWIDTH = 20,
    parameter int unsigned DW        = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic [3:0]      axi_awid,
    output logic [31:0]     axi_awaddr,
    output logic [3:0]      axi_awlen,
    output logic [2:0]      axi_awsize,
    output logic [1:0]      axi_awburst,
    output logic [1:0]      axi_awlock,
    output logic [3:0]      axi_awcache,
    output logic [2:0]      axi_awprot,
    output logic [3:0]      axi_awqos,
    output logic            axi_awvalid,
    input  logic            axi_awready,
    output logic [3:0]      axi_wid,
    output logic [DW-1:0]   axi_wdata,
    output logic [DW/8-1:0] axi_wstrb,
    output logic            axi_wlast,
    output logic            axi_wvalid,
    input  logic            axi_wready,
    input  logic [1:0]      axi_bresp,
    input  logic            axi_bvalid,
    output logic            axi_bready,
    output logic [3:0]      axi_arid,
    output logic [31:0]     axi_araddr,
    output logic [3:0]      axi_arlen,
    output logic [2:0]      axi_arsize,
    output logic [1:0]      axi_arburst,
    output logic [1:0]      axi_arlock,
    output logic [3:0]      axi_arcache,
    output logic [2:0]      axi_arprot,
    output logic [3:0]      axi_arqos,
    output logic            axi_arvalid,
    input  logic            axi_arready,
    input  logic [DW-1:0]   axi_rdata,
    input  logic [1:0]      axi_rresp,
    input  logic            axi_rvalid,
    output logic            axi_rready,
    input  logic [31:0]     bus_addr,
    input  logic            bus_wr,
    input  logic            bus_rd,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic            trig,
    output logic            busy
);

    localparam int unsigned CW    = CNTRWIDTH;
    localparam int unsigned LANES = DW / 32;
    localparam int unsigned SW    = DW / 8;
    localparam logic [31:0] AXI_PROBE_ID_CONST = 32'h5052_4F42;

    localparam logic [3:0] R_ID      = 4'd0;
    localparam logic [3:0] R_CTRL    = 4'd1;
    localparam logic [3:0] R_ADDR    = 4'd2;
    localparam logic [3:0] R_WDATA   = 4'd3;
    localparam logic [3:0] R_WSTRB   = 4'd4;
    localparam logic [3:0] R_TIMEOUT = 4'd5;
    localparam logic [3:0] R_STATUS  = 4'd6;
    localparam logic [3:0] R_RDATA   = 4'd7;
    localparam logic [3:0] R_LAT     = 4'd8;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_t;

    state_t         state, state_nxt;
    logic           arvalid_nxt, awvalid_nxt, wvalid_nxt, rready_nxt, bready_nxt;
    logic           launch, fin_r, fin_b;

    logic [31:0]    diff;
    logic           hit;
    logic [3:0]     off;
    logic           ctrl_wr, start, dir, clr;

    logic [31:0]    addr_r, wdata_r, rdata_r;
    logic [3:0]     wstrb_r;
    logic [CW-1:0]  timeout_r, tcnt, lat;
    logic           done, tmo;
    logic [1:0]     resp;

    logic [31:0]    ax_addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic           lane;

    // Constant AXI attributes: single 32-bit INCR beat, ID 0
    assign axi_awid    = 4'd0;
    assign axi_awlen   = 4'd0;
    assign axi_awsize  = 3'b010;
    assign axi_awburst = 2'b01;
    assign axi_awlock  = 2'b00;
    assign axi_awcache = 4'd0;
    assign axi_awprot  = 3'd0;
    assign axi_awqos   = 4'd0;
    assign axi_arid    = 4'd0;
    assign axi_arlen   = 4'd0;
    assign axi_arsize  = 3'b010;
    assign axi_arburst = 2'b01;
    assign axi_arlock  = 2'b00;
    assign axi_arcache = 4'd0;
    assign axi_arprot  = 3'd0;
    assign axi_arqos   = 4'd0;
    assign axi_wid     = 4'd0;
    assign axi_wlast   = 1'b1;

    // Payload is frozen at launch so register writes mid-flight cannot disturb it
    assign lane       = (LANES > 1) ? ax_addr_q[2] : 1'b0;
    assign axi_awaddr = ax_addr_q;
    assign axi_araddr = ax_addr_q;
    assign axi_wdata  = {LANES{wdata_q}};
    assign axi_wstrb  = SW'(SW'(wstrb_q) << (4 * lane));

    // Register decode
    always_comb begin
        diff    = bus_addr - BASEADDR;
        hit     = diff < 32'h0000_0040;
        off     = diff[5:2];
        ctrl_wr = bus_wr && hit && (off == R_CTRL);
        start   = ctrl_wr && bus_wdata[0];
        dir     = bus_wdata[1];
        clr     = ctrl_wr && bus_wdata[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r    <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            timeout_r <= '0;
        end else if (bus_wr && hit) begin
            case (off)
                R_ADDR:    addr_r    <= bus_wdata;
                R_WDATA:   wdata_r   <= bus_wdata;
                R_WSTRB:   wstrb_r   <= bus_wdata[3:0];
                R_TIMEOUT: timeout_r <= CW'(bus_wdata);
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_rdata <= '0;
        end else if (bus_rd && hit) begin
            case (off)
                R_ID:      bus_rdata <= AXI_PROBE_ID_CONST;
                R_ADDR:    bus_rdata <= addr_r;
                R_WDATA:   bus_rdata <= wdata_r;
                R_WSTRB:   bus_rdata <= 32'(wstrb_r);
                R_TIMEOUT: bus_rdata <= 32'(timeout_r);
                R_STATUS:  bus_rdata <= {26'd0, resp, 1'b0, tmo, done, busy};
                R_RDATA:   bus_rdata <= rdata_r;
                R_LAT:     bus_rdata <= 32'(lat);
                default:   bus_rdata <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            axi_arvalid <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_rready  <= 1'b0;
            axi_bready  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            axi_arvalid <= arvalid_nxt;
            axi_awvalid <= awvalid_nxt;
            axi_wvalid  <= wvalid_nxt;
            axi_rready  <= rready_nxt;
            axi_bready  <= bready_nxt;
            busy        <= (state_nxt != S_IDLE);
        end
    end

    // Next state and next values of the registered handshake outputs
    always_comb begin
        state_nxt   = state;
        arvalid_nxt = axi_arvalid;
        awvalid_nxt = axi_awvalid;
        wvalid_nxt  = axi_wvalid;
        rready_nxt  = 1'b0;
        bready_nxt  = 1'b0;
        launch      = 1'b0;
        fin_r       = 1'b0;
        fin_b       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    launch = 1'b1;
                    if (dir) begin
                        state_nxt   = S_AW_W;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                    end else begin
                        state_nxt   = S_AR;
                        arvalid_nxt = 1'b1;
                    end
                end
            end
            S_AR: begin
                if (axi_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = S_R;
                end
            end
            S_R: begin
                if (axi_rvalid) begin
                    fin_r     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    rready_nxt = 1'b1;
                end
            end
            S_AW_W: begin
                awvalid_nxt = axi_awvalid && !axi_awready;
                wvalid_nxt  = axi_wvalid && !axi_wready;
                if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
                    bready_nxt = 1'b1;
                    state_nxt  = S_B;
                end
            end
            S_B: begin
                if (axi_bvalid) begin
                    fin_b     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    bready_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status, captured data, latency and timeout counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            tmo       <= 1'b0;
            resp      <= 2'd0;
            rdata_r   <= '0;
            lat       <= '0;
            tcnt      <= '0;
            trig      <= 1'b0;
            ax_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            trig <= 1'b0;
            if (launch) begin
                done      <= 1'b0;
                tmo       <= 1'b0;
                resp      <= 2'd0;
                lat       <= '0;
                tcnt      <= '0;
                ax_addr_q <= addr_r;
                wdata_q   <= wdata_r;
                wstrb_q   <= wstrb_r;
            end else if (state == S_IDLE) begin
                if (clr) begin
                    done    <= 1'b0;
                    tmo     <= 1'b0;
                    resp    <= 2'd0;
                    rdata_r <= '0;
                    lat     <= '0;
                end
            end else begin
                if (lat != '1) lat <= lat + CW'(1);
                if ((timeout_r != '0) && (tcnt < timeout_r)) begin
                    tcnt <= tcnt + CW'(1);
                    if ((tcnt + CW'(1)) == timeout_r) begin
                        tmo  <= 1'b1;
                        trig <= 1'b1;
                    end
                end
                if (fin_r) begin
                    rdata_r <= 32'(axi_rdata >> (32 * lane));
                    resp    <= axi_rresp;
                    done    <= 1'b1;
                end
                if (fin_b) begin
                    resp <= axi_bresp;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_probe.sv
// Directed bench for axi_probe: a 32-bit instance at 0x000 and a 64-bit instance at 0x100.
module tb_axi_probe;

    localparam logic [31:0] A_ID = 32'h00, A_CTRL = 32'h04, A_ADDR = 32'h08, A_WDATA = 32'h0C;
    localparam logic [31:0] A_WSTRB = 32'h10, A_TMO = 32'h14, A_STAT = 32'h18, A_RDATA = 32'h1C;
    localparam logic [31:0] A_LAT = 32'h20, B_OFS = 32'h100;

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] bus_addr = '0, bus_wdata = '0;
    logic bus_wr = 1'b0, bus_rd = 1'b0;
    logic [31:0] bus_rdata_a, bus_rdata_b;

    // 32-bit instance
    logic [3:0] awid, awlen, awcache, awqos, wid, arid, arlen, arcache, arqos;
    logic [31:0] awaddr, araddr, wdata, rdata = '0;
    logic [2:0] awsize, awprot, arsize, arprot;
    logic [1:0] awburst, awlock, arburst, arlock, bresp = '0, rresp = '0;
    logic [3:0] wstrb;
    logic awvalid, wvalid, wlast, bready, arvalid, rready, trig_a, busy_a;
    logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;

    // 64-bit instance
    logic [3:0] awid_b, awlen_b, awcache_b, awqos_b, wid_b, arid_b, arlen_b, arcache_b, arqos_b;
    logic [31:0] awaddr_b, araddr_b;
    logic [63:0] wdata_b, rdata_b = '0;
    logic [2:0] awsize_b, awprot_b, arsize_b, arprot_b;
    logic [1:0] awburst_b, awlock_b, arburst_b, arlock_b;
    logic [7:0] wstrb_b;
    logic awvalid_b, wvalid_b, wlast_b, bready_b, arvalid_b, rready_b, trig_b, busy_b;
    logic awready_b = 0, wready_b = 0, bvalid_b = 0, arready_b = 0, rvalid_b = 0;

    axi_probe #(.BASEADDR(32'h0), .CNTRWIDTH(20), .DW(32)) u_a (
        .clk(clk), .rst(rst),
        .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
        .axi_awburst(awburst), .axi_awlock(awlock), .axi_awcache(awcache), .axi_awprot(awprot),
        .axi_awqos(awqos), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wid(wid), .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast),
        .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
        .axi_arburst(arburst), .axi_arlock(arlock), .axi_arcache(arcache), .axi_arprot(arprot),
        .axi_arqos(arqos), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata_a), .trig(trig_a), .busy(busy_a)
    );

    axi_probe #(.BASEADDR(32'h100), .CNTRWIDTH(20), .DW(64)) u_b (
        .clk(clk), .rst(rst),
        .axi_awid(awid_b), .axi_awaddr(awaddr_b), .axi_awlen(awlen_b), .axi_awsize(awsize_b),
        .axi_awburst(awburst_b), .axi_awlock(awlock_b), .axi_awcache(awcache_b), .axi_awprot(awprot_b),
        .axi_awqos(awqos_b), .axi_awvalid(awvalid_b), .axi_awready(awready_b),
        .axi_wid(wid_b), .axi_wdata(wdata_b), .axi_wstrb(wstrb_b), .axi_wlast(wlast_b),
        .axi_wvalid(wvalid_b), .axi_wready(wready_b),
        .axi_bresp(2'b00), .axi_bvalid(bvalid_b), .axi_bready(bready_b),
        .axi_arid(arid_b), .axi_araddr(araddr_b), .axi_arlen(arlen_b), .axi_arsize(arsize_b),
        .axi_arburst(arburst_b), .axi_arlock(arlock_b), .axi_arcache(arcache_b), .axi_arprot(arprot_b),
        .axi_arqos(arqos_b), .axi_arvalid(arvalid_b), .axi_arready(arready_b),
        .axi_rdata(rdata_b), .axi_rresp(2'b00), .axi_rvalid(rvalid_b), .axi_rready(rready_b),
        .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata_b), .trig(trig_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, trig_cnt = 0, base;

    always @(negedge clk) if (trig_a) trig_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
        tick();
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_addr = a; bus_rd = 1'b1;
        tick();
        bus_rd = 1'b0;
        d = (a >= B_OFS) ? bus_rdata_b : bus_rdata_a;
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, 64'(d), 64'(exp));
    endtask

    typedef struct {
        logic        dir;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [31:0] sdata;
        logic [1:0]  sresp;
        logic [31:0] exp_rdata;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b0, 32'h4000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 32'h02};
        vecs[1] = '{1'b0, 32'h4000_0020, 32'h0, 4'h0, 32'h0BAD_F00D, 2'd3, 32'h0BAD_F00D, 32'h32};
        vecs[2] = '{1'b1, 32'h4000_0030, 32'h1234_5678, 4'hF, 32'h0, 2'd2, 32'h0BAD_F00D, 32'h22};
        vecs[3] = '{1'b1, 32'h4000_0034, 32'hA5A5_0F0F, 4'h3, 32'h0, 2'd0, 32'h0BAD_F00D, 32'h02};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_readies", 64'({rready, bready}), 64'd0);
        check("rst_busy_trig", 64'({busy_a, trig_a}), 64'd0);
        rst = 1'b0;
        tick();
        check_reg("rst_id", A_ID, 32'h5052_4F42);
        check_reg("rst_status", A_STAT, 32'h0);
        check_reg("rst_rdata", A_RDATA, 32'h0);
        check_reg("rst_latency", A_LAT, 32'h0);

        // Zero-wait transactions from the vector table
        base = trig_cnt;
        for (int i = 0; i < 4; i++) begin
            arready = 1; rvalid = 1; rdata = vecs[i].sdata; rresp = vecs[i].sresp;
            awready = 1; wready = 1; bvalid = 1; bresp = vecs[i].sresp;
            bus_write(A_ADDR, vecs[i].addr);
            bus_write(A_WDATA, vecs[i].wd);
            bus_write(A_WSTRB, 32'(vecs[i].ws));
            bus_write(A_CTRL, {30'd0, vecs[i].dir, 1'b1});
            check($sformatf("v%0d_busy_n1", i), 64'(busy_a), 64'd1);
            if (vecs[i].dir) begin
                check($sformatf("v%0d_awvalid", i), 64'({awvalid, wvalid, wlast}), 64'b111);
                check($sformatf("v%0d_awaddr", i), 64'(awaddr), 64'(vecs[i].addr));
                check($sformatf("v%0d_wdata", i), 64'(wdata), 64'(vecs[i].wd));
                check($sformatf("v%0d_wstrb", i), 64'(wstrb), 64'(vecs[i].ws));
            end else begin
                check($sformatf("v%0d_arvalid", i), 64'(arvalid), 64'd1);
                check($sformatf("v%0d_araddr", i), 64'(araddr), 64'(vecs[i].addr));
            end
            tick();
            check($sformatf("v%0d_ready_n2", i), 64'(vecs[i].dir ? bready : rready), 64'd1);
            tick();
            check($sformatf("v%0d_idle_n3", i), 64'(busy_a), 64'd0);
            check_reg($sformatf("v%0d_status", i), A_STAT, vecs[i].exp_status);
            check_reg($sformatf("v%0d_rdata", i), A_RDATA, vecs[i].exp_rdata);
            check_reg($sformatf("v%0d_latency", i), A_LAT, 32'd2);
        end
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0; rresp = 0;
        check("vec_no_trig", 64'(trig_cnt - base), 64'd0);

        // Write with wready 5 cycles after the AW handshake
        awready = 1; bvalid = 1;
        bus_write(A_ADDR, 32'h4000_0040);
        bus_write(A_WDATA, 32'h1234_5678);
        bus_write(A_WSTRB, 32'hF);
        bus_write(A_CTRL, 32'h3);
        check("dw_n1_valids", 64'({awvalid, wvalid, bready}), 64'b110);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check($sformatf("dw_n%0d_valids", k), 64'({awvalid, wvalid, bready}), 64'b010);
        end
        tick();
        wready = 1;
        check("dw_n6_wvalid", 64'({awvalid, wvalid, bready}), 64'b010);
        tick();
        wready = 0;
        check("dw_n7_b", 64'({awvalid, wvalid, bready, busy_a}), 64'b0011);
        tick();
        check("dw_n8_idle", 64'({bready, busy_a}), 64'b00);
        check_reg("dw_status", A_STAT, 32'h02);
        check_reg("dw_latency", A_LAT, 32'd7);
        awready = 0; bvalid = 0;

        // Timeout with late rvalid
        base = trig_cnt;
        arready = 1;
        bus_write(A_TMO, 32'd10);
        bus_write(A_ADDR, 32'h4000_0050);
        bus_write(A_CTRL, 32'h1);
        repeat (15) tick();
        check_reg("to_status_wait", A_STAT, 32'h05);
        repeat (13) tick();
        check("to_trig_once", 64'(trig_cnt - base), 64'd1);
        check("to_still_busy", 64'({busy_a, rready}), 64'b11);
        rvalid = 1; rdata = 32'hCAFE_F00D;
        tick();
        rvalid = 0; arready = 0;
        check("to_done_idle", 64'(busy_a), 64'd0);
        check_reg("to_status", A_STAT, 32'h06);
        check_reg("to_latency", A_LAT, 32'd30);
        check_reg("to_rdata", A_RDATA, 32'hCAFE_F00D);
        check("to_trig_total", 64'(trig_cnt - base), 64'd1);

        // Start and clr while busy are ignored; clr in IDLE clears
        base = trig_cnt;
        bus_write(A_TMO, 32'd2);
        bus_write(A_ADDR, 32'h4000_0100);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_ADDR, 32'h5555_0000);
        bus_write(A_CTRL, 32'h7);
        check("sb_arvalid", 64'({arvalid, awvalid, wvalid, busy_a}), 64'b1001);
        check("sb_araddr", 64'(araddr), 64'h4000_0100);
        check_reg("sb_status1", A_STAT, 32'h05);
        bus_write(A_CTRL, 32'h4);
        check_reg("sb_status2", A_STAT, 32'h05);
        arready = 1;
        tick();
        arready = 0; rvalid = 1; rdata = 32'h1111_2222;
        tick();
        rvalid = 0;
        check_reg("sb_status3", A_STAT, 32'h06);
        check_reg("sb_rdata", A_RDATA, 32'h1111_2222);
        check_reg("sb_latency", A_LAT, 32'd7);
        check("sb_trig", 64'(trig_cnt - base), 64'd1);
        bus_write(A_CTRL, 32'h4);
        check_reg("clr_status", A_STAT, 32'h0);
        check_reg("clr_rdata", A_RDATA, 32'h0);
        check_reg("clr_latency", A_LAT, 32'h0);
        bus_write(A_TMO, 32'd0);

        // 64-bit lane selection
        arready_b = 1; rvalid_b = 1; rdata_b = 64'hCAFE_BABE_0000_FFFF;
        awready_b = 1; wready_b = 1; bvalid_b = 1;
        bus_write(B_OFS + A_ADDR, 32'h4000_0004);
        bus_write(B_OFS + A_CTRL, 32'h1);
        repeat (2) tick();
        check_reg("w64_rd_upper", B_OFS + A_RDATA, 32'hCAFE_BABE);
        bus_write(B_OFS + A_ADDR, 32'h4000_0008);
        bus_write(B_OFS + A_CTRL, 32'h1);
        repeat (2) tick();
        check_reg("w64_rd_lower", B_OFS + A_RDATA, 32'h0000_FFFF);
        bus_write(B_OFS + A_ADDR, 32'h4000_0004);
        bus_write(B_OFS + A_WDATA, 32'h8765_4321);
        bus_write(B_OFS + A_WSTRB, 32'hF);
        bus_write(B_OFS + A_CTRL, 32'h3);
        check("w64_wstrb_hi", 64'(wstrb_b), 64'hF0);
        check("w64_wdata", wdata_b, 64'h8765_4321_8765_4321);
        repeat (2) tick();
        bus_write(B_OFS + A_ADDR, 32'h4000_0008);
        bus_write(B_OFS + A_CTRL, 32'h3);
        check("w64_wstrb_lo", 64'(wstrb_b), 64'h0F);
        repeat (2) tick();
        check_reg("w64_status", B_OFS + A_STAT, 32'h02);
        arready_b = 0; rvalid_b = 0; awready_b = 0; wready_b = 0; bvalid_b = 0;

        // Reset mid-transaction drops valids at once
        bus_write(A_ADDR, 32'h4000_0200);
        bus_write(A_CTRL, 32'h1);
        check("mr_arvalid_before", 64'(arvalid), 64'd1);
        rst = 1'b1;
        #1;
        check("mr_arvalid_after", 64'({arvalid, busy_a}), 64'b00);
        tick();
        rst = 1'b0;
        tick();
        check_reg("mr_status", A_STAT, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_probe.md
# axi_probe

Debug AXI3 initiator for on-target bus probing, the active counterpart to the passive AXI3 activity watchdog in the debug subsystem. The CPU programs an address, direction, data and timeout over int_bus. The block issues one single-beat AXI3 read or write and records the response, read data and latency. A trig pulse for ILA capture fires if the response does not arrive within the timeout.

## Interface
- BASEADDR, 0, int_bus base address of the register file (ID constant AXI_PROBE_ID_CONST).
- CNTRWIDTH, 20, width of the timeout and latency counters.
- clk  in  1  single clock for AXI and int_bus logic.
- rst  in  1  reset, asynchronous, active-high; all state is cleared on assertion.
- axi3  axi3_interface.master  interface  AXI3 initiator port; data width DW = 32 or 64.
- bus  intbus_interf.slave  interface  register access.
- trig  out  1  one-cycle timeout pulse for ILA.
- busy  out  1  transaction in flight.

## Operation
- Registers:
  - CTRL: bit0 start (pulse), bit1 dir (1 = write), bit2 clr (pulse).
  - ADDR[31:0], WDATA[31:0], WSTRB[3:0].
  - TIMEOUT[CNTRWIDTH-1:0]; 0 disables the timeout.
  - STATUS (read-only): bit0 busy, bit1 done, bit2 timeout, bits5:4 resp.
  - RDATA[31:0] and LATENCY[CNTRWIDTH-1:0] (read-only).
- Fixed AXI fields:
  - id 0, len 0, size 3'b010, burst INCR, lock/cache/prot/qos 0.
  - wlast = 1 whenever wvalid is high; wid 0.
  - Write data is WDATA replicated across all DW/32 lanes. wstrb is WSTRB placed in the lane selected by ADDR[2] (DW = 64), zeros elsewhere.
  - Read data is captured from the lane selected by ADDR[2] when DW = 64.
- FSM states: IDLE, AR, R, AW_W, B.
- IDLE:
  - start with dir = 0 goes to AR.
  - start with dir = 1 goes to AW_W.
  - Entering either state clears done, timeout and resp, and zeroes both counters.
- AR: arvalid high; on arvalid & arready go to R.
- R:
  - rready high.
  - On rvalid, latch RDATA and rresp, set done, go to IDLE.
- AW_W:
  - awvalid and wvalid are both raised on entry. Each drops independently on its own handshake.
  - When both handshakes are complete (in either order or in the same cycle), go to B.
- B: bready high; on bvalid, latch bresp, set done, go to IDLE.
- Protocol rule: a valid, once asserted, stays high with stable payload until its handshake. The timeout never aborts a transaction.
- Timeout:
  - The counter increments every non-IDLE cycle and saturates at TIMEOUT.
  - When the count first equals a nonzero TIMEOUT, the timeout bit sets and trig pulses for 1 cycle.
  - The FSM keeps waiting after the timeout.
- Latency: counts non-IDLE cycles, saturates at all-ones, and freezes at the final handshake.
- A start received while busy is ignored.
- clr in IDLE zeroes STATUS, RDATA and LATENCY. clr while busy is ignored.

## Timing
- Reset values: all AXI valids and readies 0, trig 0, busy 0, FSM in IDLE, STATUS/RDATA/LATENCY 0.
- If the start pulse is seen in cycle N, arvalid (or awvalid/wvalid) is high in cycle N+1 and busy is high from N+1.
- A read with arready and rvalid both held high completes as follows:
  - AR handshake in N+1, R in N+2, RDATA valid and done = 1 in N+3.
  - LATENCY = 2.
- A zero-wait write follows the same timing: AW/W in N+1, B in N+2, LATENCY = 2.
- trig goes high in the cycle after the counter reaches TIMEOUT. At most one pulse per transaction.
- rst mid-transaction drops all valids immediately, which is legal only with a bus-wide reset. The block returns to IDLE.

## Test plan
- Zero-wait read: ADDR = 0x40000010, slave returns 0xDEADBEEF with OKAY → RDATA = 0xDEADBEEF, resp = 0, LATENCY = 2, trig never high.
- Write with wready delayed 5 cycles after awready: WDATA = 0x12345678, WSTRB = 0xF → wvalid held 5 extra cycles, bready only in B, done = 1, awvalid low after its handshake.
- Timeout: TIMEOUT = 10, slave never asserts rvalid → a single trig pulse, timeout = 1, busy stays 1. rvalid arriving at cycle 30 then completes with LATENCY = 30.
- Error response: bresp = SLVERR → STATUS resp = 2, done = 1.
- Start while busy plus clr while busy → both ignored, the in-flight transaction is unchanged. clr in IDLE then zeroes STATUS.
- DW = 64 read of ADDR = 0x...4 → RDATA taken from the upper lane. A write to the same address → wstrb = 0xF0.
